// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter and its pending-write scoreboard.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic {
        ALU_FIRST = 1'b0,
        LD_FORCED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// One pending bit per register for in-flight long-latency results, with two
// combinational hazard lookups for the decode stage.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic [ADDR_W-1:0] rd_addr2_i,
    output logic              hazard1_o,
    output logic              hazard2_o
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Clear is applied before set so a same-cycle issue to the returning register stays pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            pending_d[set_addr_i] = 1'b1;
        end
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign hazard1_o = pending_q[rd_addr1_i];
    assign hazard2_o = pending_q[rd_addr2_i];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU and long-latency writeback
// paths: ALU has priority, a starvation counter eventually forces the load path.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W       = regfile_pkg::ADDR_W,
    parameter int DATA_W       = regfile_pkg::DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aluValid,
    output logic              aluReady,
    input  logic [ADDR_W-1:0] aluAddr,
    input  logic [DATA_W-1:0] aluData,
    input  logic              ldValid,
    output logic              ldReady,
    input  logic [ADDR_W-1:0] ldAddr,
    input  logic [DATA_W-1:0] ldData,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueAddr,
    input  logic [ADDR_W-1:0] readAddr1,
    input  logic [ADDR_W-1:0] readAddr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [DATA_W-1:0] writeData
);

    localparam logic [CNT_W-1:0]  LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(REG_ZERO);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              alu_gnt, ld_gnt;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        aluReady = 1'b0;
        ldReady  = 1'b0;
        unique case (state_q)
            ALU_FIRST: begin
                aluReady = aluValid;
                ldReady  = ldValid && !aluValid;
                if (ldValid && !ldReady) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    if (cnt_d >= LIMIT) begin
                        state_d = LD_FORCED;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            LD_FORCED: begin
                // Either the load is granted now or it has withdrawn; both return to ALU priority.
                ldReady = ldValid;
                cnt_d   = '0;
                state_d = ALU_FIRST;
            end
            default: begin
                state_d = ALU_FIRST;
                cnt_d   = '0;
            end
        endcase
    end

    assign alu_gnt = aluValid && aluReady;
    assign ld_gnt  = ldValid && ldReady;

    // Writes to register 0 complete the handshake but never reach the register file.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (alu_gnt && aluAddr != ZERO_A) begin
            wr_en_d   = 1'b1;
            wr_addr_d = aluAddr;
            wr_data_d = aluData;
        end else if (ld_gnt && ldAddr != ZERO_A) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ldAddr;
            wr_data_d = ldData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ALU_FIRST;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign RegWrite  = wr_en_q;
    assign writeAddr = wr_addr_q;
    assign writeData = wr_data_q;

    regfile_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en_i  (issueValid),
        .set_addr_i(issueAddr),
        .clr_en_i  (ld_gnt),
        .clr_addr_i(ldAddr),
        .rd_addr1_i(readAddr1),
        .rd_addr2_i(readAddr2),
        .hazard1_o (hazard1),
        .hazard2_o (hazard2)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed scenarios plus randomized
// traffic checked against a rule-level reference model.
module tb_regfile_write_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        aluValid, ldValid, issueValid;
    logic        aluReady, ldReady, hazard1, hazard2, RegWrite;
    logic [4:0]  aluAddr, ldAddr, issueAddr, readAddr1, readAddr2, writeAddr;
    logic [31:0] aluData, ldData, writeData;

    regfile_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .aluValid(aluValid), .aluReady(aluReady), .aluAddr(aluAddr), .aluData(aluData),
        .ldValid(ldValid), .ldReady(ldReady), .ldAddr(ldAddr), .ldData(ldData),
        .issueValid(issueValid), .issueAddr(issueAddr),
        .readAddr1(readAddr1), .readAddr2(readAddr2),
        .hazard1(hazard1), .hazard2(hazard2),
        .RegWrite(RegWrite), .writeAddr(writeAddr), .writeData(writeData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          due;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

    int  m_streak;
    bit  m_forced;
    bit  m_pend[32];
    bit  g_alu, g_ld, d_ld;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_streak = 0;
        m_forced = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        aluValid = 0; aluAddr = 0; aluData = 0;
        ldValid = 0; ldAddr = 0; ldData = 0;
        issueValid = 0; issueAddr = 0;
        readAddr1 = 0; readAddr2 = 0;
    endtask

    // One clock cycle of stimulus; readiness and hazards checked against the model mid-cycle.
    task automatic cycle(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit lv, input logic [4:0] la, input logic [31:0] ld,
                         input bit iv, input logic [4:0] ia,
                         input logic [4:0] r1, input logic [4:0] r2);
        bit e_alu, e_ld;
        @(posedge clk);
        #1;
        aluValid = av; aluAddr = aa; aluData = ad;
        ldValid = lv; ldAddr = la; ldData = ld;
        issueValid = iv; issueAddr = ia;
        readAddr1 = r1; readAddr2 = r2;
        @(negedge clk);
        e_alu = m_forced ? 1'b0 : av;
        e_ld  = m_forced ? lv : (lv && !av);
        chk("aluReady", 32'(aluReady), 32'(e_alu));
        chk("ldReady", 32'(ldReady), 32'(e_ld));
        chk("hazard1", 32'(hazard1), 32'(m_pend[r1]));
        chk("hazard2", 32'(hazard2), 32'(m_pend[r2]));
        d_ld  = ldReady;
        g_alu = e_alu;
        g_ld  = e_ld;
        if (g_alu && aa != 0) exp_q.push_back('{a: aa, d: ad, due: cyc + 1});
        else if (g_ld && la != 0) exp_q.push_back('{a: la, d: ld, due: cyc + 1});
        if (g_ld) m_pend[la] = 0;
        if (iv && ia != 0) m_pend[ia] = 1;
        if (m_forced) begin
            m_forced = 0;
            m_streak = 0;
        end else if (lv && !g_ld) begin
            m_streak++;
            if (m_streak >= LIMIT) m_forced = 1;
        end else begin
            m_streak = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every write presented by the DUT must match the oldest expected write, on time.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (RegWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %0d data %h expected no write", writeAddr, writeData);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("writeAddr", 32'(writeAddr), 32'(e.a));
                    chk("writeData", writeData, e.d);
                    chk("write_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_write: got RegWrite 0 expected write addr %0d data %h", exp_q[0].a, exp_q[0].d);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic reset_now();
        #2;
        rst_n = 0;
        #1;
        chk("rst_RegWrite", 32'(RegWrite), 0);
        chk("rst_writeAddr", 32'(writeAddr), 0);
        chk("rst_writeData", writeData, 0);
        chk("rst_hazard1", 32'(hazard1), 0);
        chk("rst_hazard2", 32'(hazard2), 0);
        model_reset();
        drive_idle();
        #1;
        chk("rst_aluReady", 32'(aluReady), 0);
        chk("rst_ldReady", 32'(ldReady), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        bit         ra_v, rl_v;
        logic [4:0] ra_a, rl_a;
        logic [31:0] ra_d, rl_d;
        int         refused;

        drive_idle();
        model_reset();
        rst_n = 0;
        #1;
        chk("init_RegWrite", 32'(RegWrite), 0);
        chk("init_writeAddr", 32'(writeAddr), 0);
        chk("init_writeData", writeData, 0);
        chk("init_hazard1", 32'(hazard1), 0);
        chk("init_aluReady", 32'(aluReady), 0);
        chk("init_ldReady", 32'(ldReady), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        // Reset with a load grant in flight, then a first ALU write after release.
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);
        cycle(0, 0, 0, 1, 5'd9, 32'h0badf00d, 0, 0, 5'd9, 5'd9);
        reset_now();
        cycle(1, 5'd3, 32'h12345678, 0, 0, 0, 0, 0, 5'd9, 0);
        idle(2);

        // Priority: ALU wins, load follows once ALU drops.
        cycle(1, 5'd1, 32'habc12345, 1, 5'd2, 32'h30663220, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 5'd2, 32'h30663220, 0, 0, 0, 0);
        idle(2);

        // Starvation: ALU held, load refused exactly LIMIT times then forced.
        refused = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 5'd4, 32'h44440000 + i, 1, 5'd5, 32'hdeadbeef, 0, 0, 0, 0);
            if (d_ld) break;
            refused++;
        end
        chk("starve_refusals", 32'(refused), LIMIT);
        cycle(1, 5'd4, 32'h4444aaaa, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Scoreboard set, set-beats-clear, then clear.
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
        cycle(0, 0, 0, 1, 5'd7, 32'h77777777, 1, 5'd7, 5'd7, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
        cycle(0, 0, 0, 1, 5'd7, 32'h70707070, 0, 0, 5'd7, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
        idle(1);

        // Register 0: handshake completes, no write, no pending bit.
        cycle(1, 5'd0, 32'hffffffff, 0, 0, 0, 1, 5'd0, 5'd0, 0);
        cycle(0, 0, 0, 1, 5'd0, 32'h00000001, 0, 0, 5'd0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);

        // Idle stretch, then starvation timing must restart from zero.
        idle(10);
        refused = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 5'd6, 32'h66660000 + i, 1, 5'd8, 32'h88888888, 0, 0, 0, 0);
            if (d_ld) break;
            refused++;
        end
        chk("starve_refusals_2", 32'(refused), LIMIT);
        idle(2);

        // Randomized traffic with protocol-respecting held requests.
        ra_v = 0; rl_v = 0; ra_a = 0; rl_a = 0; ra_d = 0; rl_d = 0;
        for (int i = 0; i < 600; i++) begin
            if (!ra_v || g_alu) begin
                ra_v = ($urandom_range(0, 99) < 55);
                ra_a = 5'($urandom);
                ra_d = $urandom;
            end
            if (!rl_v || g_ld) begin
                rl_v = ($urandom_range(0, 99) < 50);
                rl_a = 5'($urandom);
                rl_d = $urandom;
            end
            cycle(ra_v, ra_a, ra_d, rl_v, rl_a, rl_d,
                  ($urandom_range(0, 99) < 30), 5'($urandom),
                  5'($urandom), 5'($urandom));
            if (!ra_v) g_alu = 1;
            if (!rl_v) g_ld = 1;
            if (i == 300) begin
                reset_now();
                ra_v = 0; rl_v = 0;
            end
        end
        idle(3);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback sources:
  - the single-cycle ALU pipeline;
  - the multi-cycle load / mul-div return path.
- Arbitrates with fixed ALU priority plus a starvation guard.
- Keeps a pending-write scoreboard so the decode stage can stall on RAW hazards against in-flight long-latency results.
- Sits between the writeback stage and the register file's writeAddr / writeData / RegWrite inputs.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- STARVE_LIMIT, 4, consecutive refused-load cycles before the load path is forced.
- CNT_W, 3, starvation counter width; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- aluValid  in  1  ALU writeback request.
- aluReady  out  1  ALU request granted this cycle.
- aluAddr  in  ADDR_W  ALU destination register.
- aluData  in  DATA_W  ALU result.
- ldValid  in  1  long-latency writeback request.
- ldReady  out  1  long-latency request granted this cycle.
- ldAddr  in  ADDR_W  long-latency destination register.
- ldData  in  DATA_W  long-latency result.
- issueValid  in  1  a long-latency op issues this cycle.
- issueAddr  in  ADDR_W  destination of the issuing op.
- readAddr1  in  ADDR_W  decode source operand 1.
- readAddr2  in  ADDR_W  decode source operand 2.
- hazard1  out  1  readAddr1 has a pending write.
- hazard2  out  1  readAddr2 has a pending write.
- RegWrite  out  1  register-file write enable.
- writeAddr  out  ADDR_W  register-file write address.
- writeData  out  DATA_W  register-file write data.

Behaviour:
- Reset (async, rst_n low):
  - RegWrite=0, writeAddr=0, writeData=0.
  - Scoreboard all 0; starvation counter 0; FSM in ALU_FIRST.
  - aluReady, ldReady and hazard1/2 are combinational; with no requests and an empty scoreboard they read 0.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - Requesters hold addr/data stable while valid && !ready.
  - At most one grant per cycle.
- FSM ALU_FIRST:
  - aluReady = aluValid.
  - ldReady = ldValid && !aluValid.
  - Counter increments each cycle ldValid && !ldReady (saturating); it clears on any ld grant or when ldValid is low.
  - When the counter reaches STARVE_LIMIT (same-cycle compare after the increment), next state is LD_FORCED.
- FSM LD_FORCED:
  - ldReady = ldValid; aluReady = 0.
  - On ld grant → ALU_FIRST, counter 0.
  - If ldValid drops → ALU_FIRST, counter 0.
- Write port (registered, latency 1):
  - A grant in cycle N drives RegWrite/writeAddr/writeData in cycle N+1 with the granted addr/data.
  - RegWrite=0 in any cycle following no grant; writeAddr/writeData hold their last values.
- Register 0:
  - A granted request with addr 0 completes its handshake.
  - It does not assert RegWrite.
  - It does not touch the scoreboard.
- Scoreboard (one pending bit per register, bit 0 tied 0):
  - Set on issueValid && issueAddr!=0.
  - Cleared on an ld grant to ldAddr.
  - Same cycle set and clear of the same address: set wins.
  - ALU grants never clear bits.
- Hazards:
  - hazardK = pending[readAddrK], combinational from the registered bits.
  - No bypass: a bit cleared by a grant in cycle N reads 0 from cycle N+1.
  - Issuing to an already-pending register leaves the bit set; decode prevents this by stalling.
- Reset mid-operation: all state clears immediately and any grant in flight is dropped; requesters re-present after reset.

Decomposition:
- Shared package (regfile_pkg):
  - ADDR_W, DATA_W, NUM_REGS=32, REG_ZERO=0.
  - Arbiter state typedef {ALU_FIRST, LD_FORCED}.
- One natural sub-module: regfile_scoreboard.
  - Contains the pending bit vector, set/clear logic and the two hazard lookups.
  - The arbiter FSM, counter and output register stay in the top module.

Test Plan:
- Reset: rst_n low mid-cycle with ld grant pending → RegWrite=0 and hazard1/2=0 immediately; after release the first ALU grant (addr 3, data 32'h12345678) gives RegWrite=1, writeAddr=3, writeData=32'h12345678 exactly one cycle later.
- Priority: aluValid and ldValid both high for 1 cycle (alu addr 1 = 32'habc12345, ld addr 2 = 32'h30663220) → aluReady=1, ldReady=0; next cycle ld granted once aluValid drops; writes appear in order addr 1 then addr 2.
- Starvation: aluValid held high, ldValid high (addr 5, 32'hdeadbeef) → ldReady=0 for 4 cycles, then ldReady=1 and aluReady=0 for one cycle; next cycle writeAddr=5; ALU is re-granted the following cycle.
- Scoreboard: issueValid with issueAddr 7 → with readAddr1=7, hazard1=1 from the next cycle; ld grant to addr 7 → hazard1=0 the cycle after; same-cycle issue 7 plus clear 7 → hazard1 stays 1.
- Register 0: ALU grant to addr 0 with data 32'hffffffff → aluReady=1, RegWrite stays 0; issueAddr 0 → hazard on readAddr1=0 stays 0.
- Idle: no valids for 10 cycles → RegWrite=0 throughout and the counter stays 0 (then verify 4-cycle starvation timing restarts from zero).
